// File: rtl/mp3_track_fetcher_if.sv
// ROM read bus plus the word stream toward the SDI serializer.
// master = track fetcher, slave = ROM / serializer side.
interface mp3_track_fetcher_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output rom_addr, word_data, word_valid,
        input  rom_data, word_ready
    );

    modport slave (
        input  rom_addr, word_data, word_valid,
        output rom_data, word_ready
    );
endinterface

// File: rtl/mp3_track_fetcher.sv
// Track fetcher: walks a track's ROM window and queues the returned words in a
// 2-entry FIFO for the serializer, with optional looping and end-of-track pulse.
module mp3_track_fetcher #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int NUM_TRACKS = 4,
    parameter int TRK_W      = 2,
    parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_BASE = {10'd768, 10'd640, 10'd512, 10'd0},
    parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_LEN  = {10'd128, 10'd128, 10'd128, 10'd512}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TRK_W-1:0]      i_track_sel,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_loop_en,
    mp3_track_fetcher_if.master   bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TRK_W-1:0]      o_cur_track
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              r_busy;
    logic              r_done;
    logic [TRK_W-1:0]  r_cur_track;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_last;
    logic [1:0]        w_occ;
    logic [ADDR_W-1:0] w_new_base;
    logic [ADDR_W-1:0] w_new_len;
    logic [ADDR_W-1:0] w_cur_base;
    logic [ADDR_W-1:0] w_cur_len;

    assign w_new_base = TRACK_BASE[i_track_sel*ADDR_W +: ADDR_W];
    assign w_new_len  = TRACK_LEN[i_track_sel*ADDR_W +: ADDR_W];
    assign w_cur_base = TRACK_BASE[r_cur_track*ADDR_W +: ADDR_W];
    assign w_cur_len  = TRACK_LEN[r_cur_track*ADDR_W +: ADDR_W];

    assign w_pop  = (r_count != 2'd0) && bus.word_ready;
    assign w_push = r_inflight;
    // Occupancy counts the in-flight read so the FIFO can never overflow.
    assign w_occ   = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_issue = (r_state == S_FETCH) && (r_remaining != '0) && (w_occ < 2'd2);
    assign w_last  = (r_remaining == ADDR_W'(1));

    assign bus.rom_addr   = r_addr;
    assign bus.word_data  = r_mem[r_rd_ptr];
    assign bus.word_valid = (r_count != 2'd0);
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_cur_track    = r_cur_track;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_track <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.rom_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                S_FETCH: begin
                    if (w_issue) begin
                        // Wrap reloads the base directly so the next issue is the first word again.
                        if (w_last && i_loop_en) begin
                            r_addr      <= w_cur_base;
                            r_remaining <= w_cur_len;
                        end else begin
                            r_addr      <= r_addr + 1'b1;
                            r_remaining <= r_remaining - 1'b1;
                            if (w_last)
                                r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == 2'd0 && !r_inflight) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Stop beats start; start while busy is an abort plus a fresh load.
            if (i_stop) begin
                r_count    <= 2'd0;
                r_inflight <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_wr_ptr   <= 1'b0;
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
            end else if (i_start) begin
                r_count     <= 2'd0;
                r_inflight  <= 1'b0;
                r_rd_ptr    <= 1'b0;
                r_wr_ptr    <= 1'b0;
                r_cur_track <= i_track_sel;
                r_addr      <= w_new_base;
                r_remaining <= w_new_len;
                r_state     <= (w_new_len == '0) ? S_DRAIN : S_FETCH;
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mp3_track_fetcher.sv
// Directed bench for mp3_track_fetcher: ROM model, expected-word scoreboard
// and immediate-assertion checks on every handshake and control output.
module tb_mp3_track_fetcher;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [TW-1:0] track_sel;
    logic start, stop, loop_en, z_start;
    logic busy, done, z_busy, z_done;
    logic [TW-1:0] cur_track, z_cur;

    mp3_track_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mp3_track_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) zbus ();

    mp3_track_fetcher dut (
        .clk(clk), .rst(rst), .i_track_sel(track_sel), .i_start(start), .i_stop(stop),
        .i_loop_en(loop_en), .bus(bus), .o_busy(busy), .o_done(done), .o_cur_track(cur_track)
    );

    mp3_track_fetcher #(.TRACK_LEN({10'd128, 10'd128, 10'd128, 10'd0})) dut_z (
        .clk(clk), .rst(rst), .i_track_sel(track_sel), .i_start(z_start), .i_stop(1'b0),
        .i_loop_en(1'b0), .bus(zbus), .o_busy(z_busy), .o_done(z_done), .o_cur_track(z_cur)
    );

    assign zbus.word_ready = 1'b1;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {16'hA5C3, 6'd0, a};
    endfunction

    always @(posedge clk) begin
        bus.rom_data  <= rom_word(bus.rom_addr);
        zbus.rom_data <= rom_word(zbus.rom_addr);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected words are queued at stimulus time, popped on handshake.
    logic [31:0] exp_q [$];
    int pop_cnt = 0, done_cnt = 0, first_pop = 0, last_pop = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (bus.word_valid && bus.word_ready) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_word: observed %0h expected none", bus.word_data);
                end
                if (exp_q.size() != 0) chk("word", bus.word_data, exp_q.pop_front());
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
            if (pv && !pr && bus.word_valid) chk("stall_hold", bus.word_data, pd);
            if (done) done_cnt++;
            pv = bus.word_valid;
        end
        pr = bus.word_ready;
        pd = bus.word_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [TW-1:0] sel);
        track_sel = sel;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic fill(input int base, input int len, input int total);
        for (int i = 0; i < total; i++) exp_q.push_back(rom_word(10'(base + (i % len))));
    endtask

    task automatic wait_pops(input string tag, input int n, input int lim);
        for (int i = 0; i < lim && pop_cnt < n; i++) tick(1);
        chk(tag, 32'(pop_cnt), 32'(n));
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done; i++) tick(1);
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_addr"},  32'(bus.rom_addr), 32'd0);
        chk({p, "_valid"}, 32'(bus.word_valid), 32'd0);
        chk({p, "_data"},  bus.word_data, 32'd0);
        chk({p, "_busy"},  32'(busy), 32'd0);
        chk({p, "_done"},  32'(done), 32'd0);
        chk({p, "_track"}, 32'(cur_track), 32'd0);
    endtask

    int d0;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; z_start = 1'b0;
        track_sel = '0; bus.word_ready = 1'b0;
        tick(3);
        chk_reset("rst");
        rst = 1'b0;
        tick(1);

        // Track 1, free-running consumer
        d0 = done_cnt; pop_cnt = 0; bus.word_ready = 1'b1;
        fill(512, 128, 128);
        pulse_start(2'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_track", 32'(cur_track), 32'd1);
        chk("t1_base", 32'(bus.rom_addr), 32'd512);
        chk("t1_valid_c0", 32'(bus.word_valid), 32'd0);
        tick(1);
        chk("t1_valid_c1", 32'(bus.word_valid), 32'd0);
        chk("t1_addr_c1", 32'(bus.rom_addr), 32'd513);
        tick(1);
        chk("t1_valid_c2", 32'(bus.word_valid), 32'd1);
        chk("t1_first", bus.word_data, rom_word(10'd512));
        wait_done(400);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        tick(1);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_words", 32'(pop_cnt), 32'd128);
        chk("t1_rate", 32'(last_pop - first_pop), 32'd127);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Backpressure: ready one cycle in three
        bus.word_ready = 1'b0; pop_cnt = 0; d0 = done_cnt;
        fill(512, 128, 128);
        pulse_start(2'd1);
        for (int i = 0; i < 2000 && !done; i++) begin
            bus.word_ready = (i % 3 == 0);
            tick(1);
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_words", 32'(pop_cnt), 32'd128);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        bus.word_ready = 1'b0;
        tick(1);

        // Looping track 2 for 300 words
        loop_en = 1'b1; pop_cnt = 0; d0 = done_cnt; bus.word_ready = 1'b1;
        fill(640, 128, 300);
        pulse_start(2'd2);
        wait_pops("t3_words", 300, 1000);
        bus.word_ready = 1'b0;
        pulse_stop();
        loop_en = 1'b0;
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        tick(2);
        chk("t3_no_done", 32'(done_cnt - d0), 32'd0);

        // Stop after word 40 of track 0, then replay track 0
        pop_cnt = 0; d0 = done_cnt; bus.word_ready = 1'b1;
        fill(0, 512, 40);
        pulse_start(2'd0);
        wait_pops("t4_words", 40, 200);
        bus.word_ready = 1'b0;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t4_valid", 32'(bus.word_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        tick(3);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        pop_cnt = 0;
        fill(0, 512, 5);
        pulse_start(2'd0);
        chk("t4_restart_addr", 32'(bus.rom_addr), 32'd0);
        bus.word_ready = 1'b1;
        wait_pops("t4_words2", 5, 50);
        bus.word_ready = 1'b0;
        pulse_stop();
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Restart while busy: track 3 -> track 1
        pulse_start(2'd3);
        tick(4);
        chk("t5_t3_valid", 32'(bus.word_valid), 32'd1);
        chk("t5_t3_head", bus.word_data, rom_word(10'd768));
        pop_cnt = 0; d0 = done_cnt;
        fill(512, 128, 4);
        pulse_start(2'd1);
        chk("t5_flush", 32'(bus.word_valid), 32'd0);
        chk("t5_addr", 32'(bus.rom_addr), 32'd512);
        chk("t5_track", 32'(cur_track), 32'd1);
        bus.word_ready = 1'b1;
        wait_pops("t5_words", 4, 50);
        bus.word_ready = 1'b0;
        pulse_stop();
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Start and stop together: stop wins
        pulse_start(2'd2);
        tick(3);
        track_sel = 2'd1; start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd0);
        chk("t5b_valid", 32'(bus.word_valid), 32'd0);
        chk("t5b_track", 32'(cur_track), 32'd2);
        bus.word_ready = 1'b1;
        tick(5);
        chk("t5b_idle_valid", 32'(bus.word_valid), 32'd0);
        chk("t5b_no_words", 32'(pop_cnt), 32'd4);
        chk("t5b_no_done", 32'(done_cnt - d0), 32'd0);
        bus.word_ready = 1'b0;

        // Zero-length track on the second instance
        track_sel = 2'd0; z_start = 1'b1;
        tick(1);
        z_start = 1'b0;
        chk("t6_busy", 32'(z_busy), 32'd1);
        chk("t6_done_c0", 32'(z_done), 32'd0);
        tick(1);
        chk("t6_done_c1", 32'(z_done), 32'd1);
        chk("t6_idle", 32'(z_busy), 32'd0);
        chk("t6_valid", 32'(zbus.word_valid), 32'd0);
        tick(1);
        chk("t6_done_c2", 32'(z_done), 32'd0);

        // Reset in the middle of FETCH
        pulse_start(2'd0);
        tick(3);
        chk("t7_pre_valid", 32'(bus.word_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        chk_reset("t7");
        rst = 1'b0;
        tick(3);
        chk("t7_stays_idle", 32'(busy), 32'd0);
        chk("t7_no_valid", 32'(bus.word_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
